i2c_xfer_ctrl: RTL and testbench

Transaction-level sequencer for the I2C master. It accepts a single transfer request from the register block: 7-bit address, direction and byte count. It then drives the byte-level bus engine through a START, ADDR, DATA…, STOP command sequence. It reports completion, NACK and arbitration loss as one-cycle status pulses, which the register block latches into STS_TD, STS_NA and STS_AF.

---
 rtl/i2c_xfer_ctrl_pkg.sv | 14 +
 rtl/i2c_xfer_ctrl_if.sv | 37 +++
 rtl/i2c_xfer_ctrl.sv | 122 ++++++++++++
 tb/tb_i2c_xfer_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/i2c_xfer_ctrl_pkg.sv
// i2c_xfer_ctrl_pkg: byte-engine command encodings and status pulse bit order
package i2c_xfer_ctrl_pkg;
  typedef enum logic [2:0] {
    CMD_NONE  = 3'b000,
    CMD_START = 3'b001,
    CMD_STOP  = 3'b010,
    CMD_WRITE = 3'b011,
    CMD_READ  = 3'b100
  } cmd_e;
  localparam int STS_TD = 0;
  localparam int STS_NA = 1;
  localparam int STS_AF = 2;
  localparam int STS_W  = 3;
endpackage

// File: rtl/i2c_xfer_ctrl_if.sv
// i2c_xfer_ctrl_if: register-block request, tx/rx byte streams, engine command bus and status
interface i2c_xfer_ctrl_if #(parameter int LEN_W = 5);
  logic             ctl_go;
  logic [6:0]       ctl_addr;
  logic             ctl_rw;
  logic [LEN_W-1:0] ctl_len;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic [2:0]       bc_cmd;
  logic             bc_req;
  logic [7:0]       bc_din;
  logic             bc_nack;
  logic             bc_done;
  logic [7:0]       bc_dout;
  logic             bc_ackin;
  logic             bc_al;
  logic             busy;
  logic             sts_td;
  logic             sts_na;
  logic             sts_af;
  logic [LEN_W-1:0] byte_cnt;
  modport master (
    input  ctl_go, ctl_addr, ctl_rw, ctl_len, tx_data, tx_valid,
           bc_done, bc_dout, bc_ackin, bc_al,
    output tx_ready, rx_data, rx_valid, bc_cmd, bc_req, bc_din, bc_nack,
           busy, sts_td, sts_na, sts_af, byte_cnt
  );
  modport slave (
    output ctl_go, ctl_addr, ctl_rw, ctl_len, tx_data, tx_valid,
           bc_done, bc_dout, bc_ackin, bc_al,
    input  tx_ready, rx_data, rx_valid, bc_cmd, bc_req, bc_din, bc_nack,
           busy, sts_td, sts_na, sts_af, byte_cnt
  );
endinterface

// File: rtl/i2c_xfer_ctrl.sv
// i2c_xfer_ctrl: sequences START, ADDR, DATA..., STOP commands to the byte engine for one transfer
module i2c_xfer_ctrl
  import i2c_xfer_ctrl_pkg::*;
#(
  parameter int LEN_W = 5
) (
  input logic           clk,
  input logic           reset,
  i2c_xfer_ctrl_if.master bus
);
  typedef enum logic [2:0] {IDLE, START, ADDR, WDATA, RDATA, STOP, DONE} state_e;
  state_e           state;
  logic [6:0]       addr;
  logic             rw;
  logic             na_flag;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] nxt;
  logic [STS_W-1:0] sts;
  assign nxt = (bus.byte_cnt == len) ? bus.byte_cnt : bus.byte_cnt + 1'b1;
  assign bus.sts_td = sts[STS_TD];
  assign bus.sts_na = sts[STS_NA];
  assign bus.sts_af = sts[STS_AF];
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      addr         <= '0;
      rw           <= 1'b0;
      len          <= '0;
      na_flag      <= 1'b0;
      sts          <= '0;
      bus.bc_req   <= 1'b0;
      bus.bc_cmd   <= CMD_NONE;
      bus.bc_din   <= '0;
      bus.bc_nack  <= 1'b0;
      bus.tx_ready <= 1'b0;
      bus.rx_valid <= 1'b0;
      bus.rx_data  <= '0;
      bus.busy     <= 1'b0;
      bus.byte_cnt <= '0;
    end else begin
      sts          <= '0;
      bus.tx_ready <= 1'b0;
      bus.rx_valid <= 1'b0;
      if (state != IDLE && bus.bc_al) begin
        state      <= IDLE;
        bus.bc_req <= 1'b0;
        bus.busy   <= 1'b0;
        sts[STS_AF] <= 1'b1;
      end else begin
        case (state)
          IDLE: if (bus.ctl_go) begin
            addr         <= bus.ctl_addr;
            rw           <= bus.ctl_rw;
            len          <= bus.ctl_len;
            na_flag      <= 1'b0;
            bus.byte_cnt <= '0;
            bus.busy     <= 1'b1;
            bus.bc_req   <= 1'b1;
            bus.bc_cmd   <= CMD_START;
            state        <= START;
          end
          START: if (bus.bc_done) begin
            bus.bc_cmd <= CMD_WRITE;
            bus.bc_din <= {addr, rw};
            state      <= ADDR;
          end
          ADDR: if (bus.bc_done) begin
            if (bus.bc_ackin || len == '0) begin
              na_flag    <= bus.bc_ackin;
              bus.bc_cmd <= CMD_STOP;
              state      <= STOP;
            end else if (rw) begin
              bus.bc_cmd  <= CMD_READ;
              bus.bc_nack <= len == 1;
              state       <= RDATA;
            end else begin
              bus.bc_req <= 1'b0;
              state      <= WDATA;
            end
          end
          WDATA: if (!bus.bc_req) begin
            if (bus.tx_valid) begin
              bus.tx_ready <= 1'b1;
              bus.bc_din   <= bus.tx_data;
              bus.bc_cmd   <= CMD_WRITE;
              bus.bc_req   <= 1'b1;
            end
          end else if (bus.bc_done) begin
            bus.byte_cnt <= nxt;
            if (bus.bc_ackin || nxt == len) begin
              na_flag    <= bus.bc_ackin;
              bus.bc_cmd <= CMD_STOP;
              state      <= STOP;
            end else bus.bc_req <= 1'b0;
          end
          RDATA: if (bus.bc_done) begin
            bus.rx_data  <= bus.bc_dout;
            bus.rx_valid <= 1'b1;
            bus.byte_cnt <= nxt;
            bus.bc_nack  <= nxt == len - 1'b1;
            if (nxt == len) begin
              bus.bc_cmd  <= CMD_STOP;
              bus.bc_nack <= 1'b0;
              state       <= STOP;
            end
          end
          STOP: if (bus.bc_done) begin
            bus.bc_req  <= 1'b0;
            sts[STS_NA] <= na_flag;
            sts[STS_TD] <= !na_flag;
            state       <= DONE;
          end
          DONE: begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_xfer_ctrl.sv
// tb_i2c_xfer_ctrl: directed transfers against a hand-driven byte engine
module tb_i2c_xfer_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0, errors = 0;
  int ntx = 0, nrx = 0, ntd = 0, nna = 0, naf = 0;
  int t0, r0, d0, n0, a0;
  logic [7:0] rxlog [4];
  i2c_xfer_ctrl_if #(.LEN_W(5)) bus ();
  i2c_xfer_ctrl #(.LEN_W(5)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.tx_ready) ntx++;
    if (bus.rx_valid) begin
      rxlog[nrx % 4] = bus.rx_data;
      nrx++;
    end
    if (bus.sts_td) ntd++;
    if (bus.sts_na) nna++;
    if (bus.sts_af) naf++;
  end
  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic snap();
    t0 = ntx; r0 = nrx; d0 = ntd; n0 = nna; a0 = naf;
  endtask
  task automatic go(input logic [6:0] a, input logic r, input logic [4:0] l);
    bus.ctl_addr = a;
    bus.ctl_rw   = r;
    bus.ctl_len  = l;
    bus.ctl_go   = 1'b1;
    @(negedge clk);
    bus.ctl_go   = 1'b0;
  endtask
  task automatic eng(input logic [2:0] cmd, input logic [7:0] din, input logic nack,
                     input logic [7:0] dout, input logic ack, input logic al, input string tag);
    for (int n = 0; n < 100 && !bus.bc_req; n++) @(negedge clk);
    bus.tx_valid = 1'b0;
    chk(bus.bc_req, 1, {tag, " req"});
    chk(bus.bc_cmd, cmd, {tag, " cmd"});
    if (cmd == 3'b011) chk(bus.bc_din, din, {tag, " din"});
    if (cmd == 3'b100) chk(bus.bc_nack, nack, {tag, " nack"});
    bus.bc_done  = 1'b1;
    bus.bc_dout  = dout;
    bus.bc_ackin = ack;
    bus.bc_al    = al;
    @(negedge clk);
    bus.bc_done  = 1'b0;
    bus.bc_ackin = 1'b0;
    bus.bc_al    = 1'b0;
  endtask
  function automatic logic [31:0] outs();
    return {bus.bc_req, bus.bc_cmd, bus.bc_din, bus.bc_nack, bus.tx_ready, bus.rx_valid,
            bus.rx_data, bus.busy, bus.sts_td, bus.sts_na, bus.sts_af, bus.byte_cnt};
  endfunction
  initial begin
    bus.ctl_go = 0; bus.ctl_addr = 0; bus.ctl_rw = 0; bus.ctl_len = 0;
    bus.tx_data = 0; bus.tx_valid = 0;
    bus.bc_done = 0; bus.bc_dout = 0; bus.bc_ackin = 0; bus.bc_al = 0;
    repeat (3) @(negedge clk);
    chk(outs(), 0, "reset outputs");
    reset = 1'b0;
    @(negedge clk);
    chk(outs(), 0, "idle outputs");
    snap();
    go(7'h50, 0, 2);
    chk(bus.bc_req, 1, "go latency req");
    chk(bus.busy, 1, "go busy");
    eng(3'b001, 0, 0, 0, 0, 0, "w START");
    eng(3'b011, 8'hA0, 0, 0, 0, 0, "w ADDR");
    bus.tx_data = 8'hA5; bus.tx_valid = 1;
    eng(3'b011, 8'hA5, 0, 0, 0, 0, "w D0");
    bus.tx_data = 8'h3C; bus.tx_valid = 1;
    eng(3'b011, 8'h3C, 0, 0, 0, 0, "w D1");
    eng(3'b010, 0, 0, 0, 0, 0, "w STOP");
    chk(bus.sts_td, 1, "w sts_td in DONE");
    repeat (2) @(negedge clk);
    chk(bus.busy, 0, "w busy cleared");
    chk(ntd - d0, 1, "w td count");
    chk(nna - n0, 0, "w na count");
    chk(bus.byte_cnt, 2, "w byte_cnt");
    chk(ntx - t0, 2, "w tx_ready count");
    snap();
    go(7'h51, 1, 3);
    eng(3'b001, 0, 0, 0, 0, 0, "r START");
    eng(3'b011, 8'hA3, 0, 0, 0, 0, "r ADDR");
    eng(3'b100, 0, 0, 8'h11, 0, 0, "r D0");
    eng(3'b100, 0, 0, 8'h22, 0, 0, "r D1");
    eng(3'b100, 0, 1, 8'h33, 0, 0, "r D2");
    eng(3'b010, 0, 0, 0, 0, 0, "r STOP");
    repeat (2) @(negedge clk);
    chk(nrx - r0, 3, "r rx count");
    chk(rxlog[r0 % 4], 8'h11, "r rx0");
    chk(rxlog[(r0 + 1) % 4], 8'h22, "r rx1");
    chk(rxlog[(r0 + 2) % 4], 8'h33, "r rx2");
    chk(ntd - d0, 1, "r td count");
    chk(bus.byte_cnt, 3, "r byte_cnt");
    snap();
    go(7'h10, 0, 4);
    eng(3'b001, 0, 0, 0, 0, 0, "dn START");
    eng(3'b011, 8'h20, 0, 0, 0, 0, "dn ADDR");
    bus.tx_data = 8'hAA; bus.tx_valid = 1;
    eng(3'b011, 8'hAA, 0, 0, 0, 0, "dn D0");
    bus.tx_data = 8'hBB; bus.tx_valid = 1;
    eng(3'b011, 8'hBB, 0, 0, 1, 0, "dn D1 nack");
    eng(3'b010, 0, 0, 0, 0, 0, "dn STOP");
    repeat (2) @(negedge clk);
    chk(nna - n0, 1, "dn na count");
    chk(ntd - d0, 0, "dn td count");
    chk(bus.byte_cnt, 2, "dn byte_cnt");
    snap();
    go(7'h22, 1, 3);
    eng(3'b001, 0, 0, 0, 0, 0, "an START");
    eng(3'b011, 8'h45, 0, 0, 1, 0, "an ADDR nack");
    eng(3'b010, 0, 0, 0, 0, 0, "an STOP");
    repeat (2) @(negedge clk);
    chk(nna - n0, 1, "an na count");
    chk(ntd - d0, 0, "an td count");
    chk(bus.byte_cnt, 0, "an byte_cnt");
    snap();
    go(7'h33, 0, 1);
    eng(3'b001, 0, 0, 0, 0, 0, "al START");
    eng(3'b011, 8'h66, 0, 0, 0, 1, "al ADDR");
    chk(bus.sts_af, 1, "al sts_af");
    chk(bus.busy, 0, "al busy");
    chk(bus.bc_req, 0, "al req dropped");
    repeat (3) @(negedge clk);
    chk(bus.bc_req, 0, "al no STOP");
    chk(naf - a0, 1, "al af count");
    chk(ntd - d0 + nna - n0, 0, "al no td/na");
    snap();
    go(7'h50, 0, 0);
    chk(bus.busy, 1, "al next go accepted");
    eng(3'b001, 0, 0, 0, 0, 0, "z START");
    eng(3'b011, 8'hA0, 0, 0, 0, 0, "z ADDR");
    eng(3'b010, 0, 0, 0, 0, 0, "z STOP");
    chk(bus.sts_td, 1, "z sts_td");
    repeat (2) @(negedge clk);
    chk(bus.byte_cnt, 0, "z byte_cnt");
    snap();
    go(7'h50, 0, 1);
    eng(3'b001, 0, 0, 0, 0, 0, "s START");
    eng(3'b011, 8'hA0, 0, 0, 0, 0, "s ADDR");
    begin
      int seen = 0;
      for (int i = 0; i < 20; i++) begin
        if (bus.bc_req) seen++;
        bus.ctl_go = (i == 5);
        bus.ctl_addr = 7'h7F; bus.ctl_rw = 1; bus.ctl_len = 5;
        @(negedge clk);
      end
      chk(seen, 0, "s req low while stalled");
    end
    bus.ctl_go = 0;
    bus.tx_data = 8'h5A; bus.tx_valid = 1;
    @(negedge clk);
    chk(bus.bc_req, 1, "s req after tx_valid");
    chk(bus.tx_ready, 1, "s tx_ready pulse");
    eng(3'b011, 8'h5A, 0, 0, 0, 0, "s D0");
    eng(3'b010, 0, 0, 0, 0, 0, "s STOP");
    chk(bus.sts_td, 1, "s sts_td");
    go(7'h11, 0, 1);
    chk(bus.busy, 0, "s go in DONE ignored");
    @(negedge clk);
    chk(bus.bc_req, 0, "s no new transfer");
    chk(bus.byte_cnt, 1, "s byte_cnt");
    chk(ntx - t0, 1, "s tx_ready count");
    go(7'h51, 1, 2);
    eng(3'b001, 0, 0, 0, 0, 0, "rst START");
    eng(3'b011, 8'hA3, 0, 0, 0, 0, "rst ADDR");
    chk(bus.bc_cmd, 3'b100, "rst in RDATA");
    snap();
    reset = 1'b1;
    @(negedge clk);
    chk(outs(), 0, "rst outputs cleared");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk(outs(), 0, "rst stays idle");
    chk(nrx - r0 + ntd - d0 + nna - n0 + naf - a0, 0, "rst no pulses");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
